// File: rtl/wdt_ctrl_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : wdt_ctrl_if
// Desc     : Request/ready register port of the watchdog core-side controller.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
interface wdt_ctrl_if;
    logic        req;
    logic        we;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic        ready;
    logic [31:0] rdata;

    modport master (output req, we, addr, wdata, input ready, rdata);
    modport slave  (input req, we, addr, wdata, output ready, rdata);
endinterface
`default_nettype wire

// File: rtl/wdt_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : wdt_ctrl
// Desc     : Watchdog register block; sequences WDEN/WDLIVE/WTOCNT changes so
//            each value is held HOLD_CYC clocks for the slow watchdog side.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
module wdt_ctrl #(
    parameter int unsigned HOLD_CYC = 32,
    parameter logic [31:0] RST_CNT  = 32'hFFFF_FFFF
) (
    input  wire        clk,
    input  wire        rst,
    wdt_ctrl_if.slave  bus,
    input  wire        wto_sync,
    output logic       WDEN,
    output logic       WDLIVE,
    output logic [31:0] WTOCNT,
    output logic       irq
);

    localparam logic [2:0] c_IDLE = 3'd0;
    localparam logic [2:0] c_HOLD = 3'd1;
    localparam logic [2:0] c_KICK = 3'd2;
    localparam logic [2:0] c_DIS  = 3'd3;
    localparam logic [2:0] c_LOAD = 3'd4;
    localparam logic [2:0] c_REEN = 3'd5;

    localparam logic [1:0] c_A_CTRL = 2'd0;
    localparam logic [1:0] c_A_LIVE = 2'd1;
    localparam logic [1:0] c_A_CNT  = 2'd2;
    localparam logic [1:0] c_A_STAT = 2'd3;

    localparam logic [7:0] c_HOLD_INIT = 8'(HOLD_CYC - 1);

    logic [2:0]  r_state, w_state_nxt;
    logic [7:0]  r_hold;
    logic        r_en, r_ie, r_to, r_err, r_wto_d;
    logic [31:0] r_shadow;

    logic        w_busy, w_acc, w_done, w_to_set, w_to_clr;
    logic        w_wden_nxt, w_wdlive_nxt, w_en_nxt, w_ie_nxt, w_err_nxt, w_to_nxt;
    logic [31:0] w_wtocnt_nxt, w_shadow_nxt;

    assign w_busy    = (r_state != c_IDLE);
    assign w_done    = (r_hold == 8'd0);
    assign w_to_set  = wto_sync & ~r_wto_d;
    // STATUS stays writable while busy so software can always clear TO/ERR
    assign bus.ready = ~(bus.req & bus.we & (bus.addr != c_A_STAT) & w_busy);
    assign w_acc     = bus.req & bus.we & bus.ready;
    assign irq       = r_to & r_ie;

    always_comb begin
        w_state_nxt  = r_state;
        w_wden_nxt   = WDEN;
        w_wdlive_nxt = WDLIVE;
        w_wtocnt_nxt = WTOCNT;
        w_shadow_nxt = r_shadow;
        w_en_nxt     = r_en;
        w_ie_nxt     = r_ie;
        w_err_nxt    = r_err;
        w_to_clr     = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (w_acc) begin
                    case (bus.addr)
                        c_A_CTRL: begin
                            w_en_nxt    = bus.wdata[0];
                            w_ie_nxt    = bus.wdata[1];
                            w_wden_nxt  = bus.wdata[0];
                            w_state_nxt = c_HOLD;
                        end
                        c_A_LIVE: begin
                            w_wdlive_nxt = 1'b1;
                            w_state_nxt  = c_KICK;
                        end
                        c_A_CNT: begin
                            if (bus.wdata == 32'd0) begin
                                w_err_nxt = 1'b1;
                            end else if (!r_en) begin
                                w_wtocnt_nxt = bus.wdata;
                                w_state_nxt  = c_HOLD;
                            end else begin
                                // count may only change while the watchdog is disabled
                                w_wden_nxt   = 1'b0;
                                w_shadow_nxt = bus.wdata;
                                w_state_nxt  = c_DIS;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            c_HOLD: if (w_done) w_state_nxt = c_IDLE;
            c_KICK: begin
                if (w_done) begin
                    w_wdlive_nxt = 1'b0;
                    w_state_nxt  = c_IDLE;
                end
            end
            c_DIS: begin
                if (w_done) begin
                    w_wtocnt_nxt = r_shadow;
                    w_state_nxt  = c_LOAD;
                end
            end
            c_LOAD: begin
                if (w_done) begin
                    w_wden_nxt  = 1'b1;
                    w_state_nxt = c_REEN;
                end
            end
            c_REEN: if (w_done) w_state_nxt = c_IDLE;
            default: w_state_nxt = c_IDLE;
        endcase

        if (w_acc && (bus.addr == c_A_STAT)) begin
            w_to_clr = bus.wdata[0];
            if (bus.wdata[2]) w_err_nxt = 1'b0;
        end
        w_to_nxt = w_to_set | (r_to & ~w_to_clr);
    end

    always_comb begin
        bus.rdata = 32'd0;
        if (bus.req && !bus.we) begin
            case (bus.addr)
                c_A_CTRL: bus.rdata = {30'd0, r_ie, r_en};
                c_A_CNT:  bus.rdata = WTOCNT;
                c_A_STAT: bus.rdata = {29'd0, r_err, w_busy, r_to};
                default:  bus.rdata = 32'd0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= c_IDLE;
            r_hold  <= 8'd0;
        end else begin
            r_state <= w_state_nxt;
            if (w_state_nxt != r_state) begin
                r_hold <= c_HOLD_INIT;
            end else if (!w_done) begin
                r_hold <= r_hold - 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            WDEN     <= 1'b0;
            WDLIVE   <= 1'b0;
            WTOCNT   <= RST_CNT;
            r_shadow <= 32'd0;
            r_en     <= 1'b0;
            r_ie     <= 1'b0;
            r_to     <= 1'b0;
            r_err    <= 1'b0;
            r_wto_d  <= 1'b0;
        end else begin
            WDEN     <= w_wden_nxt;
            WDLIVE   <= w_wdlive_nxt;
            WTOCNT   <= w_wtocnt_nxt;
            r_shadow <= w_shadow_nxt;
            r_en     <= w_en_nxt;
            r_ie     <= w_ie_nxt;
            r_to     <= w_to_nxt;
            r_err    <= w_err_nxt;
            r_wto_d  <= wto_sync;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_wdt_ctrl.sv
`default_nettype none
// Bench for wdt_ctrl: directed scenarios plus random register traffic, all
// checked every cycle against an event-timeline model of the register block.
module tb_wdt_ctrl;
    localparam int          H    = 32;
    localparam logic [31:0] RSTV = 32'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst;
    logic        wto_sync;
    logic        WDEN, WDLIVE, irq;
    logic [31:0] WTOCNT;

    wdt_ctrl_if bus();

    wdt_ctrl #(.HOLD_CYC(H), .RST_CNT(RSTV)) dut (
        .clk(clk), .rst(rst), .bus(bus), .wto_sync(wto_sync),
        .WDEN(WDEN), .WDLIVE(WDLIVE), .WTOCNT(WTOCNT), .irq(irq)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    logic chk_on = 1'b0;

    // Model: register values plus a list of timed output changes.
    typedef struct { int t; int kind; logic [31:0] v; } ev_t;
    ev_t         evq[$];
    int          m_now, m_busy_end;
    logic        m_en, m_ie, m_to, m_err, m_wden, m_wdlive, m_wto_prev;
    logic [31:0] m_wtocnt;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic m_busy();
        return m_now < m_busy_end;
    endfunction

    function automatic logic exp_ready();
        return !(bus.req && bus.we && bus.addr != 2'd3 && m_busy());
    endfunction

    function automatic logic [31:0] exp_read(input logic [1:0] a);
        case (a)
            2'd0:    return {30'd0, m_ie, m_en};
            2'd1:    return 32'd0;
            2'd2:    return m_wtocnt;
            default: return {29'd0, m_err, m_busy(), m_to};
        endcase
    endfunction

    task automatic m_reset();
        m_en = 0; m_ie = 0; m_to = 0; m_err = 0;
        m_wden = 0; m_wdlive = 0; m_wto_prev = 0;
        m_wtocnt = RSTV;
        m_busy_end = m_now;
        evq.delete();
    endtask

    task automatic model_step();
        logic acc, rise;
        acc  = bus.req && bus.we && exp_ready();
        rise = wto_sync && !m_wto_prev;
        if (!rst) begin
            m_reset();
            return;
        end
        m_now++;
        m_wto_prev = wto_sync;
        for (int i = evq.size() - 1; i >= 0; i--) begin
            if (evq[i].t == m_now) begin
                case (evq[i].kind)
                    0:       m_wden   = evq[i].v[0];
                    1:       m_wdlive = evq[i].v[0];
                    default: m_wtocnt = evq[i].v;
                endcase
                evq.delete(i);
            end
        end
        if (acc) begin
            case (bus.addr)
                2'd0: begin
                    m_en = bus.wdata[0]; m_ie = bus.wdata[1]; m_wden = bus.wdata[0];
                    m_busy_end = m_now + H;
                end
                2'd1: begin
                    m_wdlive = 1;
                    evq.push_back('{m_now + H, 1, 32'd0});
                    m_busy_end = m_now + H;
                end
                2'd2: begin
                    if (bus.wdata == 0) m_err = 1;
                    else if (!m_en) begin
                        m_wtocnt = bus.wdata;
                        m_busy_end = m_now + H;
                    end else begin
                        m_wden = 0;
                        evq.push_back('{m_now + H, 2, bus.wdata});
                        evq.push_back('{m_now + 2*H, 0, 32'd1});
                        m_busy_end = m_now + 3*H;
                    end
                end
                default: begin
                    if (bus.wdata[0]) m_to = 0;
                    if (bus.wdata[2]) m_err = 0;
                end
            endcase
        end
        if (rise) m_to = 1;
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            chk("ready", 32'(bus.ready), 32'(exp_ready()));
            if (!bus.req)     chk("rdata_noreq", bus.rdata, 32'd0);
            else if (!bus.we) chk("rdata", bus.rdata, exp_read(bus.addr));
            chk("WDEN", 32'(WDEN), 32'(m_wden));
            chk("WDLIVE", 32'(WDLIVE), 32'(m_wdlive));
            chk("WTOCNT", WTOCNT, m_wtocnt);
            chk("irq", 32'(irq), 32'(m_to && m_ie));
        end
    end

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d, output int stall);
        bus.req = 1; bus.we = 1; bus.addr = a; bus.wdata = d; stall = 0;
        #1;
        while (!bus.ready && stall < 200) begin
            step();
            stall++;
        end
        chk("wr_ready_timeout", 32'(bus.ready), 32'd1);
        step();
        bus.req = 0; bus.we = 0;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        bus.req = 1; bus.we = 0; bus.addr = a;
        #1;
        d = bus.rdata;
        step();
        bus.req = 0;
    endtask

    task automatic wait_idle(output int n);
        n = 0; bus.req = 1; bus.we = 0; bus.addr = 2'd3;
        #1;
        while (bus.rdata[1] && n < 400) begin
            step();
            n++;
        end
        chk("idle_timeout", 32'(bus.rdata[1]), 32'd0);
        bus.req = 0;
    endtask

    initial begin
        int          st, cnt, first;
        logic [31:0] d;
        rst = 0; wto_sync = 0;
        bus.req = 0; bus.we = 0; bus.addr = 0; bus.wdata = 0;
        m_now = 0;
        m_reset();
        step(); step();
        chk_on = 1;
        chk("rst_WDEN", 32'(WDEN), 32'd0);
        chk("rst_WDLIVE", 32'(WDLIVE), 32'd0);
        chk("rst_WTOCNT", WTOCNT, 32'hFFFF_FFFF);
        chk("rst_irq", 32'(irq), 32'd0);
        chk("rst_ready", 32'(bus.ready), 32'd1);
        rst = 1;
        step();

        // CNT write with EN=0, then a kick issued while busy
        wr(2'd2, 32'd100, st);
        chk("cnt100_nostall", st, 0);
        chk("cnt100_out", WTOCNT, 32'd100);
        rd(2'd3, d);
        chk("busy_set", d, 32'h2);
        step(); step(); step();
        bus.req = 1; bus.we = 1; bus.addr = 2'd1; bus.wdata = 0;
        #1;
        chk("live_stalled", 32'(bus.ready), 32'd0);
        wr(2'd1, 32'd0, st);
        chk("live_stall_len", st, 28);
        cnt = 0;
        while (WDLIVE && cnt < 100) begin cnt++; step(); end
        chk("kick_len", cnt, H);

        // EN=1 then CNT=500: disable, load, re-enable
        wr(2'd0, 32'd1, st);
        chk("ctrl_nostall", st, 0);
        chk("wden_on", 32'(WDEN), 32'd1);
        wr(2'd2, 32'd500, st);
        chk("cnt500_stall", st, H);
        chk("dis_wden", 32'(WDEN), 32'd0);
        chk("dis_oldcnt", WTOCNT, 32'd100);
        cnt = 0; first = -1;
        while (!WDEN && cnt < 200) begin
            if (WTOCNT == 32'd500 && first < 0) first = cnt;
            cnt++;
            step();
        end
        chk("wden_low_len", cnt, 2*H);
        chk("load_delay", first, H);
        wait_idle(cnt);
        chk("reen_len", cnt, H);

        // zero count is rejected
        wr(2'd2, 32'd0, st);
        chk("cnt0_nostall", st, 0);
        chk("cnt0_keep", WTOCNT, 32'd500);
        rd(2'd3, d);
        chk("err_set", d, 32'h4);
        wr(2'd3, 32'h4, st);
        rd(2'd3, d);
        chk("err_clr", d, 32'h0);

        // timeout, interrupt, set-beats-clear
        wr(2'd0, 32'd3, st);
        wto_sync = 1;
        step();
        chk("irq_set", 32'(irq), 32'd1);
        wto_sync = 0;
        step();
        wto_sync = 1;
        wr(2'd3, 32'h1, st);
        chk("w1c_busy_nostall", st, 0);
        chk("to_set_wins", 32'(irq), 32'd1);
        wr(2'd3, 32'h1, st);
        chk("to_cleared", 32'(irq), 32'd0);
        wto_sync = 0;

        // reset in the middle of a disable phase
        wait_idle(cnt);
        wr(2'd2, 32'd777, st);
        chk("dis2_wden", 32'(WDEN), 32'd0);
        repeat (5) step();
        rst = 0;
        step();
        chk("midrst_WDEN", 32'(WDEN), 32'd0);
        chk("midrst_WTOCNT", WTOCNT, RSTV);
        rst = 1;
        rd(2'd3, d);
        chk("midrst_idle", d, 32'h0);
        rd(2'd0, d);
        chk("midrst_ctrl", d, 32'h0);
        cnt = 0;
        repeat (4*H) begin
            if (WTOCNT == 32'd777) cnt++;
            step();
        end
        chk("shadow_dropped", cnt, 0);

        // random register traffic
        for (int i = 0; i < 3000; i++) begin
            if (!(bus.req && bus.we && !bus.ready)) begin
                bus.req  = ($urandom_range(0, 9) > 3);
                bus.we   = 1'($urandom_range(0, 1));
                bus.addr = 2'($urandom_range(0, 3));
                if (bus.addr == 2'd2)
                    bus.wdata = ($urandom_range(0, 7) == 0) ? 32'd0 : 32'($urandom_range(1, 100000));
                else
                    bus.wdata = $urandom;
            end
            if ($urandom_range(0, 15) == 0) wto_sync = ~wto_sync;
            rst = ($urandom_range(0, 399) != 0);
            step();
        end

        chk_on = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/wdt_ctrl.md
# wdt_ctrl

Core-side controller for the watchdog timer. It holds the software-visible watchdog registers (enable, kick, timeout count, status) behind a simple request/ready register port. It drives WDEN/WDLIVE/WTOCNT to the watchdog, sequencing every change so each value stays stable long enough for the watchdog's slow sampling and synchronizer chain to capture it. It also latches the synchronized timeout pulse into a sticky status bit and interrupt line.

## Interface
- HOLD_CYC, 32: clk cycles every output change is held stable before the next change; must be ≥ 8×(sample period) + sync depth margin; legal range 2..255.
- RST_CNT, 32'hFFFF_FFFF: reset value of the WTOCNT register/output.
- clk  input  1  core clock; all logic on rising edge.
- rst  input  1  reset, synchronous, active-low (rst=0 resets on next clk edge).
- req  input  1  register access request.
- we  input  1  1 = write, 0 = read; valid with req.
- addr  input  2  word select: 0 CTRL, 1 LIVE, 2 CNT, 3 STATUS.
- wdata  input  32  write data.
- ready  output  1  access completes in cycle where req && ready.
- rdata  output  32  read data, valid combinationally in completing cycle.
- wto_sync  input  1  WTO already synchronized into clk domain (pulse/level).
- WDEN  output  1  registered watchdog enable.
- WDLIVE  output  1  registered kick.
- WTOCNT  output  32  registered timeout count.
- irq  output  1  timeout interrupt = STATUS.TO && CTRL.IE.

## Operation
- Registers: CTRL bit0 EN, bit1 IE; LIVE write-only (any write = kick, reads 0); CNT 32-bit; STATUS bit0 TO (sticky, W1C), bit1 BUSY (RO), bit2 ERR (sticky, W1C). Unused bits read 0, writes ignored.
- Reads: ready=1 always for reads, no side effects, legal while busy.
- Writes: ready=1 only in IDLE; writes to CTRL/LIVE/CNT while busy stall (ready=0) until IDLE. STATUS writes always ready=1, even when busy.
- FSM states: IDLE, HOLD, KICK, DIS, LOAD, REEN. Single hold counter (8-bit), loaded with HOLD_CYC-1 on each state entry; state exits when counter = 0.
- IDLE + CTRL write: CTRL updated, WDEN <= wdata[0] → HOLD → IDLE. Write with unchanged EN still enters HOLD.
- IDLE + LIVE write: WDLIVE <= 1 → KICK; on exit WDLIVE <= 0 → IDLE.
- IDLE + CNT write, EN=0: WTOCNT <= wdata → HOLD → IDLE.
- IDLE + CNT write, EN=1: WDEN <= 0 → DIS; WTOCNT <= new value → LOAD; WDEN <= 1 → REEN; then IDLE. The new value is captured in a shadow register at acceptance. CTRL.EN reads 1 throughout.
- CNT write of 0: rejected; no state change, ERR <= 1, ready=1.
- BUSY = (state != IDLE).
- Timeout: rising edge of wto_sync (edge detect flop) sets TO. A simultaneous set and W1C clear leaves TO=1 (set wins).
- irq is combinational from registered TO and IE.

## Timing
- Reset (rst=0 at edge): state IDLE, WDEN=0, WDLIVE=0, WTOCNT=RST_CNT, CTRL=0, TO=0, ERR=0, edge flop=0, irq=0, ready=1, rdata=0 when no req.
- Write accepted at edge T: output changes at T; BUSY=1 from T. Each phase holds its output for exactly HOLD_CYC cycles. State returns to IDLE at edge T+HOLD_CYC (single phase) or T+3·HOLD_CYC (CNT with EN=1). ready for a stalled write rises in the IDLE cycle.
- Kick: WDLIVE high exactly HOLD_CYC cycles.
- Reset mid-sequence (any state): immediate return to reset values; a pending shadow value is discarded.
- wto_sync edge to TO=1: 1 cycle. irq follows in the same cycle as TO.

## Test plan
- Reset with rst=0 for 2 cycles → WDEN=0, WDLIVE=0, WTOCNT=FFFF_FFFF, irq=0, ready=1.
- Write CNT=100 with EN=0, HOLD_CYC=32 → WTOCNT=100 after the accept edge. BUSY=1 for 32 cycles. A LIVE write issued at cycle 5 stalls until cycle 32, then WDLIVE is high for 32 cycles.
- EN=1, write CNT=500 → WDEN low for 32 cycles, then WTOCNT=500 held 32 cycles with WDEN=0, then WDEN=1. BUSY drops at +96.
- Write CNT=0 → ERR=1, WTOCNT unchanged, no busy. W1C on STATUS bit2 → ERR=0.
- IE=1, pulse wto_sync → TO=1 and irq=1 next cycle. W1C on the same cycle as a new wto_sync edge → TO stays 1.
- Assert rst=0 mid-DIS → next edge gives WDEN=0, WTOCNT=RST_CNT, state IDLE, shadow value never driven.
